// File: rtl/op_scheduler.sv
// op_scheduler: sequences one request at a time onto a combinational ALU
// or a sequential multiplier/divider, with power-mode gating and timeouts.
module op_scheduler #(
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_op1,
  input  logic [15:0] req_op2,
  input  logic [2:0]  req_op,
  input  logic [1:0]  pmode,
  output logic        alu_en,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        mul_en,
  output logic        mul_start,
  input  logic        mul_done,
  input  logic [31:0] mul_product,
  output logic        div_en,
  output logic        div_start,
  input  logic        div_done,
  input  logic [15:0] div_quotient,
  output logic [15:0] unit_a,
  output logic [15:0] unit_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [1:0]  rsp_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_MUL,
    S_DIV,
    S_RESP,
    S_SLEEP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [15:0]   r_a;
  logic [15:0]   r_b;
  logic [31:0]   r_res;
  logic [3:0]    r_flags;
  logic [1:0]    r_err;
  logic          r_alu_en;
  logic          r_mul_en;
  logic          r_mul_start;
  logic          r_div_en;
  logic          r_div_start;
  logic          r_rsp_valid;

  logic w_shut;
  logic w_lp;
  logic w_accept;
  logic w_tmo;
  logic w_ill;
  logic w_mul;
  logic w_div;
  logic w_md;
  logic w_mhi;

  assign w_shut   = (pmode == 2'd0);
  assign w_lp     = (pmode == 2'd1);
  assign w_accept = req_valid && req_ready;
  assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
  assign w_ill    = (req_op == 3'd7);
  assign w_mul    = (req_op == 3'd0);
  assign w_div    = (req_op == 3'd1);
  assign w_md     = w_mul || w_div;
  assign w_mhi    = |mul_product[31:16];

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign req_ready  = rst && (r_state == S_IDLE) && !w_shut;
  assign alu_en     = r_alu_en;
  assign alu_op     = r_op;
  assign mul_en     = r_mul_en;
  assign mul_start  = r_mul_start;
  assign div_en     = r_div_en;
  assign div_start  = r_div_start;
  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_res;
  assign rsp_flags  = r_flags;
  assign rsp_err    = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_flags     <= '0;
      r_err       <= '0;
      r_alu_en    <= 1'b0;
      r_mul_en    <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_en    <= 1'b0;
      r_div_start <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_alu_en    <= 1'b0;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_shut) begin
            r_state <= S_SLEEP;
          end else if (w_accept) begin
            r_a     <= req_op1;
            r_b     <= req_op2;
            r_op    <= req_op;
            r_cnt   <= '0;
            r_res   <= '0;
            r_flags <= '0;
            r_err   <= 2'd0;
            unique case (1'b1)
              w_ill: begin
                r_err       <= 2'd3;
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
              end
              w_md && w_lp: begin
                r_err       <= 2'd1;
                r_state     <= S_RESP;
                r_rsp_valid <= 1'b1;
              end
              w_mul && !w_lp: begin
                r_state     <= S_MUL;
                r_mul_en    <= 1'b1;
                r_mul_start <= 1'b1;
              end
              w_div && !w_lp: begin
                r_state     <= S_DIV;
                r_div_en    <= 1'b1;
                r_div_start <= 1'b1;
              end
              default: begin
                r_state  <= S_ALU;
                r_alu_en <= 1'b1;
              end
            endcase
          end
        end
        S_ALU: begin
          r_res       <= {16'h0000, alu_result};
          r_flags     <= alu_flags;
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
        end
        S_MUL: begin
          r_cnt <= r_cnt + CW'(1);
          // A done in the final counted cycle still beats the timeout.
          if (mul_done) begin
            r_res       <= mul_product;
            r_flags     <= {w_mhi, w_mhi,
                            mul_product == 32'd0,
                            mul_product[31]};
            r_mul_en    <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else if (w_tmo) begin
            r_err       <= 2'd2;
            r_mul_en    <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          if (div_done) begin
            r_res       <= {16'h0000, div_quotient};
            r_flags     <= {2'b00,
                            div_quotient == 16'd0,
                            div_quotient[15]};
            r_div_en    <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end else if (w_tmo) begin
            r_err       <= 2'd2;
            r_div_en    <= 1'b0;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_shut ? S_SLEEP : S_IDLE;
          end
        end
        S_SLEEP: begin
          if (!w_shut) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
